// File: rtl/rl_arb_pkg.sv
// Shared types and helpers for the left/right bus arbiter slice.
// Imported by the FIFO and the arbiter top.
package rl_arb_pkg;

    typedef enum logic {SRC_L = 1'b0, SRC_R = 1'b1} src_e;

    typedef enum logic {ST_IDLE, ST_HOLD} slot_state_e;

    // Pointer width: index bits plus one wrap bit, so full and empty stay distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rl_fifo.sv
// Small synchronous FIFO with wrap-bit pointers, one instance per bus side.
// The read port is combinational: dout shows the head entry whenever the FIFO is not empty.
module rl_fifo
    import rl_arb_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          trst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/rl_bus_arbiter.sv
// Merges the left and right driver streams into one valid/ready output through a
// round-robin arbiter and a registered output slot, with saturating per-source beat counts.
module rl_bus_arbiter
    import rl_arb_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             trst_n,
    input  logic             l_valid,
    input  logic [DW-1:0]    l_data,
    output logic             l_ready,
    input  logic             r_valid,
    input  logic [DW-1:0]    r_data,
    output logic             r_ready,
    output logic             o_valid,
    output logic [DW-1:0]    o_data,
    output logic             o_src,
    input  logic             o_ready,
    output logic [CNT_W-1:0] l_count,
    output logic [CNT_W-1:0] r_count
);

    logic          l_full, l_empty, l_pop;
    logic          r_full, r_empty, r_pop;
    logic [DW-1:0] l_head, r_head;

    slot_state_e   state, state_nxt;
    src_e          last_src, sel;
    src_e          slot_src;
    logic [DW-1:0] slot_data;
    logic          load;
    logic          any_avail;
    logic          done;

    assign l_ready = !l_full;
    assign r_ready = !r_full;

    rl_fifo #(.DW(DW), .DEPTH(DEPTH)) u_l_fifo (
        .clk    (clk),
        .trst_n (trst_n),
        .push   (l_valid && l_ready),
        .din    (l_data),
        .pop    (l_pop),
        .dout   (l_head),
        .full   (l_full),
        .empty  (l_empty)
    );

    rl_fifo #(.DW(DW), .DEPTH(DEPTH)) u_r_fifo (
        .clk    (clk),
        .trst_n (trst_n),
        .push   (r_valid && r_ready),
        .din    (r_data),
        .pop    (r_pop),
        .dout   (r_head),
        .full   (r_full),
        .empty  (r_empty)
    );

    assign any_avail = !l_empty || !r_empty;
    assign done      = o_valid && o_ready;

    // Lone non-empty side wins outright; on a contest the side opposite last_src wins.
    always_comb begin
        if (l_empty)                 sel = SRC_R;
        else if (r_empty)            sel = SRC_L;
        else if (last_src == SRC_R)  sel = SRC_L;
        else                         sel = SRC_R;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_avail) begin
                    load      = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (o_ready) begin
                    load      = any_avail;
                    state_nxt = any_avail ? ST_HOLD : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign l_pop = load && (sel == SRC_L);
    assign r_pop = load && (sel == SRC_R);

    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            state     <= ST_IDLE;
            last_src  <= SRC_R;
            slot_src  <= SRC_L;
            slot_data <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                last_src  <= sel;
                slot_src  <= sel;
                slot_data <= (sel == SRC_L) ? l_head : r_head;
            end
        end
    end

    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            l_count <= '0;
            r_count <= '0;
        end else if (done) begin
            if (slot_src == SRC_L && l_count != '1) l_count <= l_count + CNT_W'(1);
            if (slot_src == SRC_R && r_count != '1) r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_valid = (state == ST_HOLD);
    assign o_data  = slot_data;
    assign o_src   = slot_src;

endmodule

// File: tb/tb_rl_bus_arbiter.sv
// Self-checking bench for rl_bus_arbiter: a table of vectors, hand sequences for the
// multi-cycle corners, and random traffic against a queue-based reference model.
module tb_rl_bus_arbiter;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             trst_n = 1'b0;
    logic             l_valid = 1'b0, r_valid = 1'b0, o_ready = 1'b0;
    logic [DW-1:0]    l_data = '0, r_data = '0;
    logic             l_ready, r_ready, o_valid, o_src;
    logic [DW-1:0]    o_data;
    logic [CNT_W-1:0] l_count, r_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rl_bus_arbiter #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .trst_n  (trst_n),
        .l_valid (l_valid),
        .l_data  (l_data),
        .l_ready (l_ready),
        .r_valid (r_valid),
        .r_data  (r_data),
        .r_ready (r_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_src   (o_src),
        .o_ready (o_ready),
        .l_count (l_count),
        .r_count (r_count)
    );

    // Reference model: two bounded queues, an output slot and a round-robin memory.
    logic [DW-1:0] lq[$];
    logic [DW-1:0] rq[$];
    bit            m_ov, m_os, m_last;
    logic [DW-1:0] m_od;
    int            m_lc, m_rc;
    logic [DW:0]   dut_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        lq.delete();
        rq.delete();
        m_ov = 0; m_os = 0; m_last = 1; m_od = '0;
        m_lc = 0; m_rc = 0;
    endtask

    task automatic compare_all();
        check("o_valid", {31'd0, o_valid}, {31'd0, m_ov});
        if (m_ov) begin
            check("o_data", {16'd0, o_data}, {16'd0, m_od});
            check("o_src",  {31'd0, o_src},  {31'd0, m_os});
        end
        check("l_ready", {31'd0, l_ready}, {31'd0, lq.size() < DEPTH});
        check("r_ready", {31'd0, r_ready}, {31'd0, rq.size() < DEPTH});
        check("l_count", {24'd0, l_count}, m_lc);
        check("r_count", {24'd0, r_count}, m_rc);
    endtask

    // One clock: log any DUT beat completing at this edge, advance the model, compare.
    task automatic step();
        bit l_acc, r_acc, done, take_l;
        if (o_valid && o_ready) dut_log.push_back({o_src, o_data});
        l_acc = l_valid && (lq.size() < DEPTH);
        r_acc = r_valid && (rq.size() < DEPTH);
        done  = m_ov && o_ready;
        @(posedge clk);
        if (done) begin
            if (m_os == 0) m_lc = (m_lc < CMAX) ? m_lc + 1 : CMAX;
            else           m_rc = (m_rc < CMAX) ? m_rc + 1 : CMAX;
        end
        if ((!m_ov || o_ready) && (lq.size() > 0 || rq.size() > 0)) begin
            take_l = (rq.size() == 0) || (lq.size() > 0 && m_last == 1);
            m_ov = 1;
            m_os = !take_l;
            m_last = !take_l;
            m_od = take_l ? lq.pop_front() : rq.pop_front();
        end else if (done) begin
            m_ov = 0;
        end
        if (l_acc) lq.push_back(l_data);
        if (r_acc) rq.push_back(r_data);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        trst_n = 1'b0;
        l_valid = 1'b0; r_valid = 1'b0; o_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        trst_n = 1'b1;
        model_clear();
        dut_log.delete();
        check("rst o_valid", {31'd0, o_valid}, 32'd0);
        check("rst o_data",  {16'd0, o_data},  32'd0);
        check("rst o_src",   {31'd0, o_src},   32'd0);
        check("rst l_ready", {31'd0, l_ready}, 32'd1);
        check("rst r_ready", {31'd0, r_ready}, 32'd1);
        check("rst l_count", {24'd0, l_count}, 32'd0);
        check("rst r_count", {24'd0, r_count}, 32'd0);
    endtask

    typedef struct {
        logic          lv;
        logic [DW-1:0] ld;
        logic          rv;
        logic [DW-1:0] rd;
        logic          ordy;
        logic          eov;
        logic [DW-1:0] eod;
        logic          eos;
        int            elc;
        int            erc;
    } vec_t;

    vec_t tbl[9];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [16:0] exp_beat;
        bit acc;
        // Single left beat, then a contested pair per side (last_src is left after the first beat).
        tbl[0] = '{1, 16'hA5A5, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0};
        tbl[1] = '{0, 16'h0000, 0, 16'h0000, 1, 1, 16'hA5A5, 0, 0, 0};
        tbl[2] = '{0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0};
        tbl[3] = '{1, 16'h1111, 1, 16'h2222, 1, 0, 16'h0000, 0, 1, 0};
        tbl[4] = '{1, 16'h1112, 1, 16'h2223, 1, 1, 16'h2222, 1, 1, 0};
        tbl[5] = '{0, 16'h0000, 0, 16'h0000, 1, 1, 16'h1111, 0, 1, 1};
        tbl[6] = '{0, 16'h0000, 0, 16'h0000, 1, 1, 16'h2223, 1, 2, 1};
        tbl[7] = '{0, 16'h0000, 0, 16'h0000, 1, 1, 16'h1112, 0, 2, 2};
        tbl[8] = '{0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 3, 2};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            l_valid = tbl[i].lv; l_data = tbl[i].ld;
            r_valid = tbl[i].rv; r_data = tbl[i].rd;
            o_ready = tbl[i].ordy;
            step();
            check($sformatf("tbl%0d o_valid", i), {31'd0, o_valid}, {31'd0, tbl[i].eov});
            if (tbl[i].eov) begin
                check($sformatf("tbl%0d o_data", i), {16'd0, o_data}, {16'd0, tbl[i].eod});
                check($sformatf("tbl%0d o_src", i),  {31'd0, o_src},  {31'd0, tbl[i].eos});
            end
            check($sformatf("tbl%0d l_count", i), {24'd0, l_count}, tbl[i].elc);
            check($sformatf("tbl%0d r_count", i), {24'd0, r_count}, tbl[i].erc);
        end

        // Asynchronous reset mid-cycle while a beat is held.
        l_valid = 1; l_data = 16'h7777; o_ready = 0;
        step();
        l_valid = 0;
        step();
        #2 trst_n = 1'b0;
        #1;
        check("async o_valid", {31'd0, o_valid}, 32'd0);
        check("async l_count", {24'd0, l_count}, 32'd0);
        check("async r_count", {24'd0, r_count}, 32'd0);
        check("async l_ready", {31'd0, l_ready}, 32'd1);
        do_reset();
        repeat (3) step();

        // Both sides loaded with four beats: strict L/R alternation.
        do_reset();
        o_ready = 1;
        for (int i = 0; i < 4; i++) begin
            l_valid = 1; l_data = 16'hC000 + 16'(i);
            r_valid = 1; r_data = 16'hD000 + 16'(i);
            step();
        end
        l_valid = 0; r_valid = 0;
        repeat (8) step();
        check("alt beats", dut_log.size(), 8);
        if (dut_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                exp_beat = (i % 2 == 0) ? {1'b0, 16'hC000 + 16'(i / 2)} : {1'b1, 16'hD000 + 16'(i / 2)};
                check($sformatf("alt beat%0d", i), {15'd0, dut_log[i]}, {15'd0, exp_beat});
            end
        end
        check("alt l_count", {24'd0, l_count}, 32'd4);
        check("alt r_count", {24'd0, r_count}, 32'd4);

        // Left fills while stalled; the slot holds the first beat; release across pointer wrap.
        do_reset();
        o_ready = 0;
        for (int i = 0; i < 5; i++) begin
            l_valid = 1; l_data = 16'hE000 + 16'(i);
            check($sformatf("fill ready%0d", i), {31'd0, l_ready}, 32'd1);
            step();
        end
        check("fill full l_ready", {31'd0, l_ready}, 32'd0);
        l_data = 16'hE005;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("stall o_data%0d", i), {16'd0, o_data}, 32'h0000E000);
            check($sformatf("stall l_ready%0d", i), {31'd0, l_ready}, 32'd0);
        end
        dut_log.delete();
        o_ready = 1;
        for (int i = 0; i < 12; i++) begin
            acc = l_valid && l_ready;
            step();
            if (acc) l_valid = 0;
        end
        check("wrap beats", dut_log.size(), 6);
        if (dut_log.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("wrap beat%0d", i), {15'd0, dut_log[i]}, {16'd0, 16'hE000 + 16'(i)});
        end

        // Saturation of the left counter.
        do_reset();
        o_ready = 1;
        for (int i = 0; i < 262; i++) begin
            l_valid = 1; l_data = DW'($urandom);
            step();
        end
        check("sat l_count", {24'd0, l_count}, CMAX);
        l_valid = 0;
        repeat (3) step();
        check("sat hold l_count", {24'd0, l_count}, CMAX);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            l_valid = ($urandom_range(0, 3) != 0);
            r_valid = ($urandom_range(0, 2) != 0);
            l_data  = DW'($urandom);
            r_data  = DW'($urandom);
            o_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
